// File: rtl/memory_access_unit.sv
// Memory stage: issues one data-memory access per execute-stage instruction and stalls upstream until ack.
// Latency 1 cycle for non-memory ops and zero-wait acks; aborts after ACK_TIMEOUT WAIT_ACK cycles.
module memory_access_unit #(
  parameter int ACK_TIMEOUT = 255
) (
  input  logic         clk,
  input  logic         reset,
  input  logic [159:0] ALU_PIPELINE_REG,
  input  logic         alu_valid,
  input  logic         MemRead_Ctrl,
  input  logic         MemWrite_Ctrl,
  output logic         mem_req,
  output logic         mem_we,
  output logic [63:0]  mem_addr,
  output logic [63:0]  mem_wdata,
  input  logic         mem_ack,
  input  logic [63:0]  mem_rdata,
  output logic         stall,
  output logic [159:0] MEM_PIPELINE_REG,
  output logic         mem_valid,
  output logic [63:0]  ForwardingPath_To_REG,
  output logic         mem_fault
);

  localparam int CW = $clog2(ACK_TIMEOUT + 1);
  localparam logic [CW-1:0] TIMEOUT_C = CW'(ACK_TIMEOUT);

  typedef enum logic [1:0] {IDLE, WAIT_ACK, ABORT} state_t;

  state_t          state_q, state_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic            run_q;
  logic [31:0]     instr_q, instr_d;
  logic [63:0]     addr_q, addr_d;
  logic [63:0]     wdata_q, wdata_d;
  logic            we_q, we_d;
  logic [159:0]    preg_q, preg_d;
  logic            valid_q, valid_d;
  logic            fault_q, fault_d;

  logic [31:0]     in_instr;
  logic [63:0]     in_alu;
  logic [63:0]     in_sd;
  logic            is_mem;

  assign in_instr = ALU_PIPELINE_REG[159:128];
  assign in_alu   = ALU_PIPELINE_REG[127:64];
  assign in_sd    = ALU_PIPELINE_REG[63:0];
  assign is_mem   = MemRead_Ctrl | MemWrite_Ctrl;

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    instr_d   = instr_q;
    addr_d    = addr_q;
    wdata_d   = wdata_q;
    we_d      = we_q;
    preg_d    = preg_q;
    valid_d   = valid_q;
    fault_d   = fault_q;
    mem_req   = 1'b0;
    mem_we    = 1'b0;
    mem_addr  = '0;
    mem_wdata = '0;
    stall     = 1'b0;

    case (state_q)
      IDLE: begin
        valid_d = 1'b0;
        // run_q keeps the request outputs quiet until the first edge after reset release
        if (run_q && alu_valid) begin
          if (!is_mem) begin
            valid_d = 1'b1;
            preg_d  = {in_instr, in_alu, in_alu};
          end else if (in_alu[2:0] != 3'd0) begin
            fault_d = 1'b1;
          end else begin
            mem_req   = 1'b1;
            mem_we    = MemWrite_Ctrl;
            mem_addr  = in_alu;
            mem_wdata = in_sd;
            stall     = !mem_ack;
            cnt_d     = '0;
            if (MemRead_Ctrl && MemWrite_Ctrl) fault_d = 1'b1;
            if (mem_ack) begin
              valid_d = 1'b1;
              preg_d  = {in_instr, in_alu, MemWrite_Ctrl ? in_sd : mem_rdata};
            end else begin
              state_d = WAIT_ACK;
              instr_d = in_instr;
              addr_d  = in_alu;
              wdata_d = in_sd;
              we_d    = MemWrite_Ctrl;
            end
          end
        end
      end

      WAIT_ACK: begin
        mem_req   = 1'b1;
        mem_we    = we_q;
        mem_addr  = addr_q;
        mem_wdata = wdata_q;
        stall     = !mem_ack;
        valid_d   = 1'b0;
        if (mem_ack) begin
          valid_d = 1'b1;
          preg_d  = {instr_q, addr_q, we_q ? wdata_q : mem_rdata};
          state_d = IDLE;
        end else begin
          cnt_d = cnt_q + CW'(1);
          if (cnt_d == TIMEOUT_C) begin
            state_d = ABORT;
            fault_d = 1'b1;
          end
        end
      end

      ABORT: begin
        valid_d = 1'b0;
        state_d = IDLE;
      end

      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      run_q   <= 1'b0;
      instr_q <= '0;
      addr_q  <= '0;
      wdata_q <= '0;
      we_q    <= 1'b0;
      preg_q  <= '0;
      valid_q <= 1'b0;
      fault_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      run_q   <= 1'b1;
      instr_q <= instr_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      we_q    <= we_d;
      preg_q  <= preg_d;
      valid_q <= valid_d;
      fault_q <= fault_d;
    end
  end

  assign MEM_PIPELINE_REG      = preg_q;
  assign mem_valid             = valid_q;
  assign ForwardingPath_To_REG = preg_q[63:0];
  assign mem_fault             = fault_q;

endmodule

// File: tb/tb_memory_access_unit.sv
// Directed and random bench for memory_access_unit against a transaction-level reference model.
module tb_memory_access_unit;
  localparam int TO = 4;

  logic         clk = 1'b0;
  logic         reset = 1'b0;
  logic [159:0] ALU_PIPELINE_REG = '0;
  logic         alu_valid = 1'b0;
  logic         MemRead_Ctrl = 1'b0;
  logic         MemWrite_Ctrl = 1'b0;
  logic         mem_req, mem_we, stall, mem_valid, mem_fault;
  logic [63:0]  mem_addr, mem_wdata, ForwardingPath_To_REG;
  logic         mem_ack = 1'b0;
  logic [63:0]  mem_rdata = '0;
  logic [159:0] MEM_PIPELINE_REG;

  int checks = 0;
  int failures = 0;
  int req_cycles = 0;

  // Reference model: one outstanding-access record plus the visible pipeline register.
  bit           m_busy, m_abort, m_fault, m_valid;
  int           m_wait;
  logic [159:0] m_preg;
  logic [31:0]  p_instr;
  logic [63:0]  p_addr, p_wdata;
  bit           p_we;
  bit           e_req, e_we, e_stall;
  logic [63:0]  e_addr, e_wdata;

  memory_access_unit #(.ACK_TIMEOUT(TO)) dut (
    .clk(clk), .reset(reset), .ALU_PIPELINE_REG(ALU_PIPELINE_REG), .alu_valid(alu_valid),
    .MemRead_Ctrl(MemRead_Ctrl), .MemWrite_Ctrl(MemWrite_Ctrl), .mem_req(mem_req), .mem_we(mem_we),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_ack(mem_ack), .mem_rdata(mem_rdata),
    .stall(stall), .MEM_PIPELINE_REG(MEM_PIPELINE_REG), .mem_valid(mem_valid),
    .ForwardingPath_To_REG(ForwardingPath_To_REG), .mem_fault(mem_fault)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [159:0] obs, input logic [159:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic set_in(input bit v, input bit rd, input bit wr, input logic [31:0] ins,
                        input logic [63:0] a, input logic [63:0] sd);
    alu_valid = v;
    MemRead_Ctrl = rd;
    MemWrite_Ctrl = wr;
    ALU_PIPELINE_REG = {ins, a, sd};
  endtask

  task automatic model_reset();
    m_busy = 0; m_abort = 0; m_fault = 0; m_valid = 0; m_wait = 0; m_preg = '0;
    e_stall = 0;
  endtask

  task automatic model_comb();
    logic [63:0] a;
    bit issue;
    a = ALU_PIPELINE_REG[127:64];
    issue = !m_busy && !m_abort && alu_valid && (MemRead_Ctrl || MemWrite_Ctrl) && (a[2:0] == 3'd0);
    e_req   = issue || m_busy;
    e_we    = m_busy ? p_we : MemWrite_Ctrl;
    e_addr  = m_busy ? p_addr : a;
    e_wdata = m_busy ? p_wdata : ALU_PIPELINE_REG[63:0];
    e_stall = e_req && !mem_ack;
  endtask

  task automatic model_next();
    logic [31:0] ins;
    logic [63:0] a, sd;
    ins = ALU_PIPELINE_REG[159:128];
    a   = ALU_PIPELINE_REG[127:64];
    sd  = ALU_PIPELINE_REG[63:0];
    if (m_abort) begin
      m_abort = 0; m_valid = 0;
    end else if (m_busy) begin
      if (mem_ack) begin
        m_busy = 0; m_valid = 1;
        m_preg = {p_instr, p_addr, p_we ? p_wdata : mem_rdata};
      end else begin
        m_valid = 0;
        m_wait++;
        if (m_wait >= TO) begin m_busy = 0; m_abort = 1; m_fault = 1; end
      end
    end else if (!alu_valid) begin
      m_valid = 0;
    end else if (!(MemRead_Ctrl || MemWrite_Ctrl)) begin
      m_valid = 1; m_preg = {ins, a, a};
    end else if (a[2:0] != 3'd0) begin
      m_valid = 0; m_fault = 1;
    end else begin
      if (MemRead_Ctrl && MemWrite_Ctrl) m_fault = 1;
      if (mem_ack) begin
        m_valid = 1; m_preg = {ins, a, MemWrite_Ctrl ? sd : mem_rdata};
      end else begin
        m_busy = 1; m_wait = 0; m_valid = 0;
        p_instr = ins; p_addr = a; p_wdata = sd; p_we = MemWrite_Ctrl;
      end
    end
  endtask

  task automatic cycle();
    @(negedge clk);
    model_comb();
    if (mem_req) req_cycles++;
    chk("mem_req", 160'(mem_req), 160'(e_req));
    chk("stall", 160'(stall), 160'(e_stall));
    if (e_req) begin
      chk("mem_we", 160'(mem_we), 160'(e_we));
      chk("mem_addr", 160'(mem_addr), 160'(e_addr));
      chk("mem_wdata", 160'(mem_wdata), 160'(e_wdata));
    end
    model_next();
    @(posedge clk);
    #1;
    chk("mem_valid", 160'(mem_valid), 160'(m_valid));
    chk("mem_pipe_reg", MEM_PIPELINE_REG, m_preg);
    chk("fwd_path", 160'(ForwardingPath_To_REG), 160'(m_preg[63:0]));
    chk("mem_fault", 160'(mem_fault), 160'(m_fault));
  endtask

  task automatic check_all_zero(input string tag);
    chk({tag, "_req"}, 160'(mem_req), 160'(0));
    chk({tag, "_we"}, 160'(mem_we), 160'(0));
    chk({tag, "_addr"}, 160'(mem_addr), 160'(0));
    chk({tag, "_wdata"}, 160'(mem_wdata), 160'(0));
    chk({tag, "_stall"}, 160'(stall), 160'(0));
    chk({tag, "_valid"}, 160'(mem_valid), 160'(0));
    chk({tag, "_preg"}, MEM_PIPELINE_REG, 160'(0));
    chk({tag, "_fault"}, 160'(mem_fault), 160'(0));
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b0;
    set_in(0, 0, 0, '0, '0, '0);
    mem_ack = 1'b0;
    #1;
    model_reset();
    check_all_zero("rst");
    @(posedge clk);
    #1;
    check_all_zero("rst_hold");
    @(negedge clk);
    #2 reset = 1'b1;
    @(posedge clk);
    #1;
  endtask

  initial begin
    do_reset();

    // Plain ALU op passes straight through.
    set_in(1, 0, 0, 32'h0000_0033, 64'h10, 64'h99);
    cycle();
    chk("add_result", 160'(ForwardingPath_To_REG), 160'(64'h10));
    set_in(0, 0, 0, '0, '0, '0);
    cycle();

    // Load with three wait cycles, ack on the fourth request cycle.
    req_cycles = 0;
    set_in(1, 1, 0, 32'h0000_0003, 64'h40, 64'h0);
    cycle(); cycle(); cycle();
    mem_ack = 1'b1; mem_rdata = 64'hDEAD_BEEF;
    cycle();
    mem_ack = 1'b0;
    chk("load_req_cycles", 160'(req_cycles), 160'(4));
    chk("load_result", 160'(ForwardingPath_To_REG), 160'(64'hDEAD_BEEF));
    chk("load_valid", 160'(mem_valid), 160'(1));

    // Zero-wait store.
    req_cycles = 0;
    set_in(1, 0, 1, 32'h0000_0023, 64'h08, 64'h55);
    mem_ack = 1'b1;
    cycle();
    mem_ack = 1'b0;
    chk("store_req_cycles", 160'(req_cycles), 160'(1));
    chk("store_result", 160'(ForwardingPath_To_REG), 160'(64'h55));
    set_in(0, 0, 0, '0, '0, '0);
    mem_ack = 1'b1;
    cycle();
    mem_ack = 1'b0;
    chk("no_fault_yet", 160'(mem_fault), 160'(0));

    // Timeout: four WAIT_ACK cycles, then a one-cycle abort bubble.
    req_cycles = 0;
    set_in(1, 1, 0, 32'h0000_0003, 64'h100, 64'h0);
    repeat (6) cycle();
    chk("timeout_req_cycles", 160'(req_cycles), 160'(1 + TO));
    chk("timeout_fault", 160'(mem_fault), 160'(1));

    // Misaligned load.
    do_reset();
    set_in(1, 1, 0, 32'h0000_0003, 64'h03, 64'h0);
    cycle();
    chk("misalign_fault", 160'(mem_fault), 160'(1));
    chk("misalign_bubble", 160'(mem_valid), 160'(0));

    // Read and write together: write wins and fault is raised.
    do_reset();
    set_in(1, 1, 1, 32'h0000_00AA, 64'h18, 64'h1234);
    cycle();
    mem_ack = 1'b1; mem_rdata = 64'hFFFF;
    cycle();
    mem_ack = 1'b0;
    chk("both_result", 160'(ForwardingPath_To_REG), 160'(64'h1234));
    chk("both_fault", 160'(mem_fault), 160'(1));

    // Reset mid-request, then a stray ack.
    do_reset();
    set_in(1, 1, 0, 32'h0000_0003, 64'h80, 64'h0);
    cycle(); cycle();
    do_reset();
    mem_ack = 1'b1; mem_rdata = 64'hBAD;
    cycle(); cycle();
    mem_ack = 1'b0;
    check_all_zero("stray_ack");

    // Random traffic with upstream freezing while stalled.
    for (int n = 0; n < 800; n++) begin
      logic [63:0] a;
      int r;
      if (n % 60 == 59) do_reset();
      if (!e_stall) begin
        a = {$urandom, $urandom};
        if ($urandom_range(0, 7) != 0) a[2:0] = 3'd0;
        r = $urandom_range(0, 9);
        set_in($urandom_range(0, 4) != 0, (r >= 4 && r <= 6) || r == 9, r >= 7,
               $urandom, a, {$urandom, $urandom});
      end
      mem_ack = ($urandom_range(0, 2) == 0);
      mem_rdata = {$urandom, $urandom};
      cycle();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
